// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 byte constants, frame FSM states, prefix helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Bytes following E1 that belong to the Pause make/break sequence
    localparam int PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_BAT)  || (b == PS2_ACK)    || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_source_if
//  Description : PS/2 pin inputs and key event / debug outputs of ps2_key_source.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_key_source_if;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;

    modport master (
        output ps2_clk_in, ps2_data_in,
        input  ps2_key, rx_byte, rx_valid, frame_err
    );

    modport slave (
        input  ps2_clk_in, ps2_data_in,
        output ps2_key, rx_byte, rx_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_frame
//  Description : Synchronise/filter PS/2 lines and deframe 11-bit PS/2 frames.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  wire logic       clk_sys,
    input  wire logic       reset,
    input  wire logic       i_ps2_clk,
    input  wire logic       i_ps2_data,
    output logic [7:0]      o_rx_byte,
    output logic            o_rx_valid,
    output logic            o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic       w_data;

    assign w_raw  = {i_ps2_data, i_ps2_clk};
    assign w_data = w_filt[1];

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic          r_s1;
        logic          r_s2;
        logic          r_f;
        logic [FW-1:0] r_cnt;

        // A level change is accepted only after FILTER_LEN consecutive differing samples
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_s1  <= 1'b1;
                r_s2  <= 1'b1;
                r_f   <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_f) begin
                    r_cnt <= '0;
                end else if (r_cnt == FW'(FILTER_LEN - 1)) begin
                    r_f   <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + FW'(1);
                end
            end
        end

        assign w_filt[g] = r_f;
    end

    logic          r_clk_d;
    logic          r_fall;
    frame_state_t  r_state;
    frame_state_t  w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          w_accept;
    logic          w_reject;
    logic          w_timeout;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_d <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_clk_d <= w_filt[0];
            r_fall  <= r_clk_d & ~w_filt[0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // A fall in the expiry cycle suppresses the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_timeout   = 1'b0;
        if ((r_state != IDLE) && !r_fall && (r_to_cnt == TW'(TIMEOUT_CYC - 1))) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
        end else if (r_fall) begin
            case (r_state)
                IDLE:    if (!w_data) w_state_nxt = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if ((^{r_shift, r_parity}) && w_data) w_accept = 1'b1;
                    else                                  w_reject = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            o_rx_byte   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (r_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY: r_parity <= w_data;
                    default: ;
                endcase
            end
            if ((r_state == IDLE) || r_fall || w_timeout) r_to_cnt <= '0;
            else                                          r_to_cnt <= r_to_cnt + TW'(1);
            if (w_accept) o_rx_byte <= r_shift;
            o_rx_valid  <= w_accept;
            o_frame_err <= w_reject | w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_source.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_source
//  Description : PS/2 receiver plus prefix decode producing the ps2_key event word.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_source
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  wire logic       clk_sys,
    input  wire logic       reset,
    ps2_key_source_if.slave bus
);

    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    logic        w_frame_err;
    logic [10:0] r_key;
    logic        r_ext;
    logic        r_brk;
    logic [2:0]  r_skip;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_ps2_clk   (bus.ps2_clk_in),
        .i_ps2_data  (bus.ps2_data_in),
        .o_rx_byte   (w_rx_byte),
        .o_rx_valid  (w_rx_valid),
        .o_frame_err (w_frame_err)
    );

    // Skip count is checked first so bytes inside the Pause sequence never act as prefixes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_key  <= '0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_rx_valid) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (w_rx_byte == PS2_PAUSE) begin
                r_skip <= 3'(PAUSE_SKIP);
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
            end else if (w_rx_byte == PS2_EXT) begin
                r_ext <= 1'b1;
            end else if (w_rx_byte == PS2_BRK) begin
                r_brk <= 1'b1;
            end else if (is_ignored(w_rx_byte)) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else begin
                r_key <= {~r_key[10], ~r_brk, r_ext, w_rx_byte};
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign bus.ps2_key   = r_key;
    assign bus.rx_byte   = w_rx_byte;
    assign bus.rx_valid  = w_rx_valid;
    assign bus.frame_err = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_source
//  Description : Directed table-driven bench for ps2_key_source.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_key_source;

    localparam int FLEN = 8;
    localparam int TOUT = 300;
    localparam int HALF = 20;
    // Pin fall to rx_valid: 2 sync + FILTER_LEN filter + fall register + output register
    localparam int LAT  = 12;

    typedef struct {
        logic [7:0]  code;
        logic        par_flip;
        logic        stop;
        logic [10:0] exp_key;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_source_if u_if();

    ps2_key_source #(
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TOUT)
    ) u_dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (u_if.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_valid = 0;
    int          n_err = 0;
    int          last_valid_cyc = 0;
    int          last_err_cyc = 0;
    int          last_key_cyc = 0;
    logic [10:0] prev_key = '0;

    always @(negedge clk) begin
        if (u_if.rx_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (u_if.frame_err === 1'b1) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (u_if.ps2_key !== prev_key) begin
            prev_key     = u_if.ps2_key;
            last_key_cyc = cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_raw(input logic [10:0] bits, input int nbits, output int fall_cyc);
        fall_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            u_if.ps2_data_in = bits[i];
            repeat (HALF) @(negedge clk);
            u_if.ps2_clk_in = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            u_if.ps2_clk_in = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        u_if.ps2_data_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop,
                              output int fall_cyc);
        logic par;
        par = (~^code) ^ par_flip;
        send_raw({stop, par, code, 1'b0}, 11, fall_cyc);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int v0, e0, fc;
        logic [10:0] kb;
        v0 = n_valid;
        e0 = n_err;
        kb = u_if.ps2_key;
        send_frame(v.code, v.par_flip, v.stop, fc);
        repeat (10) @(negedge clk);
        check({tag, " key"},   32'(u_if.ps2_key), 32'(v.exp_key));
        check({tag, " valid"}, 32'(n_valid - v0), 32'(v.exp_valid));
        check({tag, " err"},   32'(n_err - e0),   32'(v.exp_err));
        if (v.exp_valid != 0) begin
            check({tag, " rx_byte"},   32'(u_if.rx_byte), 32'(v.code));
            check({tag, " valid_lat"}, 32'(last_valid_cyc - fc), 32'(LAT));
        end
        if (v.exp_err != 0)
            check({tag, " err_lat"}, 32'(last_err_cyc - fc), 32'(LAT));
        if (v.exp_key != kb)
            check({tag, " key_lat"}, 32'(last_key_cyc - last_valid_cyc), 32'd1);
    endtask

    vec_t va[10];
    vec_t vb[14];

    initial begin
        int fc, v0, e0;
        logic [10:0] kb;

        va[0] = '{8'h1C, 1'b0, 1'b1, 11'h61C, 1, 0};
        va[1] = '{8'hF0, 1'b0, 1'b1, 11'h61C, 1, 0};
        va[2] = '{8'h1C, 1'b0, 1'b1, 11'h01C, 1, 0};
        va[3] = '{8'hE0, 1'b0, 1'b1, 11'h01C, 1, 0};
        va[4] = '{8'h75, 1'b0, 1'b1, 11'h775, 1, 0};
        va[5] = '{8'hE0, 1'b0, 1'b1, 11'h775, 1, 0};
        va[6] = '{8'hF0, 1'b0, 1'b1, 11'h775, 1, 0};
        va[7] = '{8'h75, 1'b0, 1'b1, 11'h175, 1, 0};
        va[8] = '{8'h1C, 1'b1, 1'b1, 11'h175, 0, 1};
        va[9] = '{8'h1C, 1'b0, 1'b0, 11'h175, 0, 1};

        vb[0]  = '{8'h29, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[1]  = '{8'hE1, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[2]  = '{8'h14, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[3]  = '{8'h77, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[4]  = '{8'hE1, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[5]  = '{8'hF0, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[6]  = '{8'h14, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[7]  = '{8'hF0, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[8]  = '{8'h77, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[9]  = '{8'hFA, 1'b0, 1'b1, 11'h629, 1, 0};
        vb[10] = '{8'h16, 1'b0, 1'b1, 11'h216, 1, 0};
        vb[11] = '{8'hE0, 1'b0, 1'b1, 11'h216, 1, 0};
        vb[12] = '{8'hAA, 1'b0, 1'b1, 11'h216, 1, 0};
        vb[13] = '{8'h16, 1'b0, 1'b1, 11'h616, 1, 0};

        u_if.ps2_clk_in  = 1'b1;
        u_if.ps2_data_in = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("reset ps2_key",   32'(u_if.ps2_key),   32'h0);
        check("reset rx_byte",   32'(u_if.rx_byte),   32'h0);
        check("reset rx_valid",  32'(u_if.rx_valid),  32'h0);
        check("reset frame_err", 32'(u_if.frame_err), 32'h0);

        for (int i = 0; i < 10; i++) run_vec(va[i], $sformatf("a%0d", i));

        // Start bit plus three data bits, then the lines go idle
        v0 = n_valid;
        e0 = n_err;
        kb = u_if.ps2_key;
        send_raw(11'b000_0000_0110, 4, fc);
        for (int k = 0; (k < TOUT + 200) && (n_err == e0); k++) @(negedge clk);
        check("timeout err",   32'(n_err - e0), 32'd1);
        check("timeout lat",   32'(last_err_cyc - fc), 32'(TOUT + LAT));
        check("timeout valid", 32'(n_valid - v0), 32'd0);
        check("timeout key",   32'(u_if.ps2_key), 32'(kb));

        for (int i = 0; i < 14; i++) run_vec(vb[i], $sformatf("b%0d", i));

        // Clock low glitch one sample short of the filter length
        v0 = n_valid;
        e0 = n_err;
        u_if.ps2_data_in = 1'b0;
        u_if.ps2_clk_in  = 1'b0;
        repeat (FLEN - 1) @(negedge clk);
        u_if.ps2_clk_in  = 1'b1;
        repeat (HALF) @(negedge clk);
        u_if.ps2_data_in = 1'b1;
        repeat (TOUT + 50) @(negedge clk);
        check("glitch err",   32'(n_err - e0),   32'd0);
        check("glitch valid", 32'(n_valid - v0), 32'd0);
        run_vec('{8'h5A, 1'b0, 1'b1, 11'h25A, 1, 0}, "post_glitch");

        // Reset in the middle of a frame
        v0 = n_valid;
        e0 = n_err;
        send_raw(11'b000_0001_0110, 5, fc);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (TOUT + 50) @(negedge clk);
        check("midreset err",   32'(n_err - e0),   32'd0);
        check("midreset valid", 32'(n_valid - v0), 32'd0);
        check("midreset key",   32'(u_if.ps2_key), 32'h0);
        run_vec('{8'h1C, 1'b0, 1'b1, 11'h61C, 1, 0}, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
